dmem_arbiter: RTL and testbench

Shares the single-port data RAM between the CPU memory-stage port and a DMA/loader port. CPU has fixed priority with a starvation bound for DMA, and DMA can lock the RAM for bulk fills. The block sits between `mips` and `data_ram` in `top`. It drives the RAM command combinationally from the granted requester, routes the one-cycle-late read data back to the issuing port, and produces the CPU stall.

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the CPU memory stage and the DMA/loader port.
// CPU has fixed priority, DMA gets a starvation bound and can lock the RAM for bulk fills.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_lock,
    input  logic [3:0]        dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic {ARB, LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    owner_t      rd_owner;
    logic [3:0]  starve_cnt;
    logic [31:0] cpu_hold;
    logic [31:0] dma_hold;

    // DMA overrides CPU priority once it has watched LIMIT CPU grants go by
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            if (state == LOCKED)
                dma_gnt = dma_req;
            else if (cpu_req && !(dma_req && starve_cnt == LIMIT))
                cpu_gnt = 1'b1;
            else
                dma_gnt = dma_req;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        ram_en   = cpu_gnt | dma_gnt;
        ram_we   = 4'h0;
        ram_addr = '0;
        ram_din  = 32'h0;
        if (cpu_gnt) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
        end else if (dma_gnt) begin
            ram_we   = dma_we;
            ram_addr = dma_addr;
            ram_din  = dma_wdata;
        end
    end

    // rst gates rvalid so a read outstanding across reset is dropped
    assign cpu_rvalid = !rst && rd_owner == OWN_CPU;
    assign dma_rvalid = !rst && rd_owner == OWN_DMA;
    assign cpu_rdata  = cpu_rvalid ? ram_dout : cpu_hold;
    assign dma_rdata  = dma_rvalid ? ram_dout : dma_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            rd_owner   <= OWN_NONE;
            starve_cnt <= 4'h0;
            cpu_hold   <= 32'h0;
            dma_hold   <= 32'h0;
        end else begin
            case (state)
                ARB:     if (dma_gnt && dma_lock) state <= LOCKED;
                LOCKED:  if (!dma_lock) state <= ARB;
                default: state <= ARB;
            endcase

            if (dma_gnt || !dma_req)
                starve_cnt <= 4'h0;
            else if (cpu_gnt && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'h1;

            if (cpu_gnt && cpu_we == 4'h0)
                rd_owner <= OWN_CPU;
            else if (dma_gnt && dma_we == 4'h0)
                rd_owner <= OWN_DMA;
            else
                rd_owner <= OWN_NONE;

            if (cpu_rvalid) cpu_hold <= ram_dout;
            if (dma_rvalid) dma_hold <= ram_dout;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM, a per-cycle reference model, and directed
// scenarios with hand-computed expectations.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, dma_req, dma_lock;
    logic [3:0]        cpu_we, dma_we;
    logic [ADDR_W-1:0] cpu_addr, dma_addr;
    logic [31:0]       cpu_wdata, dma_wdata;
    logic              cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0]       cpu_rdata, dma_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din, ram_dout;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Single-port synchronous RAM
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'h0) ram_dout <= ram[ram_addr];
            else ram[ram_addr] <= merge(ram[ram_addr], ram_din, ram_we);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: who wins, what the RAM holds, what each port should see
    logic [31:0] m_mem [256];
    bit          m_valid  = 0;
    bit          m_locked = 0;
    int          m_waited = 0;     // CPU grants DMA has sat through
    int          m_owner  = 0;     // 0 none, 1 cpu, 2 dma
    logic [31:0] m_pend   = 0;
    logic [31:0] m_hc     = 0;
    logic [31:0] m_hd     = 0;

    always @(negedge clk) begin
        bit          e_cg, e_dg, e_cv, e_dv;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_din;
        e_cg = 0; e_dg = 0;
        if (!rst) begin
            if (m_locked) e_dg = dma_req;
            else if (cpu_req && !(dma_req && m_waited >= LIMIT)) e_cg = 1;
            else e_dg = dma_req;
        end
        e_cv   = !rst && m_owner == 1;
        e_dv   = !rst && m_owner == 2;
        e_we   = e_cg ? cpu_we : e_dg ? dma_we : 4'h0;
        e_addr = e_cg ? 32'(cpu_addr) : e_dg ? 32'(dma_addr) : 32'h0;
        e_din  = e_cg ? cpu_wdata : e_dg ? dma_wdata : 32'h0;

        if (m_valid) begin
            chk("cpu_gnt",    32'(cpu_gnt),    32'(e_cg));
            chk("dma_gnt",    32'(dma_gnt),    32'(e_dg));
            chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !e_cg));
            chk("ram_en",     32'(ram_en),     32'(e_cg || e_dg));
            chk("ram_we",     32'(ram_we),     32'(e_we));
            chk("ram_addr",   32'(ram_addr),   e_addr);
            chk("ram_din",    ram_din,         e_din);
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cv));
            chk("dma_rvalid", 32'(dma_rvalid), 32'(e_dv));
            chk("cpu_rdata",  cpu_rdata,       e_cv ? m_pend : m_hc);
            chk("dma_rdata",  dma_rdata,       e_dv ? m_pend : m_hd);
        end

        if (rst) begin
            m_valid = 1; m_locked = 0; m_waited = 0; m_owner = 0; m_hc = 0; m_hd = 0;
        end else begin
            if (m_owner == 1) m_hc = m_pend;
            if (m_owner == 2) m_hd = m_pend;
            m_owner = 0;
            if (e_cg) begin
                if (cpu_we == 0) begin m_owner = 1; m_pend = m_mem[cpu_addr]; end
                else m_mem[cpu_addr] = merge(m_mem[cpu_addr], cpu_wdata, cpu_we);
            end
            if (e_dg) begin
                if (dma_we == 0) begin m_owner = 2; m_pend = m_mem[dma_addr]; end
                else m_mem[dma_addr] = merge(m_mem[dma_addr], dma_wdata, dma_we);
            end
            if (e_dg || !dma_req) m_waited = 0;
            else if (e_cg && m_waited < LIMIT) m_waited++;
            if (!m_locked && e_dg && dma_lock) m_locked = 1;
            else if (m_locked && !dma_lock) m_locked = 0;
        end
    end

    task automatic idle();
        cpu_req = 0; cpu_we = 0; dma_req = 0; dma_lock = 0; dma_we = 0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    logic [31:0] rd_exp [3];

    initial begin
        for (int a = 0; a < 256; a++) begin ram[a] = 0; m_mem[a] = 0; end
        ram[8'h10] = 32'h11; ram[8'h11] = 32'h22; ram[8'h12] = 32'h33;
        m_mem[8'h10] = 32'h11; m_mem[8'h11] = 32'h22; m_mem[8'h12] = 32'h33;
        rd_exp[0] = 32'h11; rd_exp[1] = 32'h22; rd_exp[2] = 32'h33;

        rst = 1; idle(); cpu_req = 1;
        cpu_addr = 0; cpu_wdata = 0; dma_addr = 0; dma_wdata = 0;
        next(); #2;
        chk("rst_stall", 32'(cpu_stall), 32'h1);
        chk("rst_gnt",   32'(cpu_gnt),   32'h0);
        chk("rst_ram_en", 32'(ram_en),   32'h0);
        next(); rst = 0; idle(); #2;
        chk("rst_rdata", cpu_rdata, 32'h0);

        // CPU-only reads of 0x10..0x12
        for (int i = 0; i < 3; i++) begin
            next(); cpu_req = 1; cpu_we = 0; cpu_addr = 8'(8'h10 + i); #2;
            chk("rd_gnt", 32'(cpu_gnt), 32'h1);
            chk("rd_stall", 32'(cpu_stall), 32'h0);
            if (i > 0) chk("rd_data", cpu_rdata, rd_exp[i-1]);
        end
        next(); idle(); #2;
        chk("rd_last_valid", 32'(cpu_rvalid), 32'h1);
        chk("rd_last_data", cpu_rdata, 32'h33);

        // Contention: C,C,C,C,D repeating
        for (int i = 0; i < 10; i++) begin
            next(); cpu_req = 1; cpu_addr = 8'h20; dma_req = 1; dma_addr = 8'h21; #2;
            chk("starve_cpu_gnt", 32'(cpu_gnt), 32'(i % 5 != 4));
            chk("starve_stall", 32'(cpu_stall), 32'(i % 5 == 4));
        end

        // dma_lock without a grant must not lock
        next(); dma_lock = 1; #2;
        chk("lock_nogrant_cpu", 32'(cpu_gnt), 32'h1);
        next(); dma_req = 0; dma_lock = 0; #2;
        chk("lock_nogrant_after", 32'(cpu_gnt), 32'h1);

        // Partial write then readback
        next(); cpu_we = 4'b0011; cpu_addr = 8'h30; cpu_wdata = 32'hDEADBEEF;
        next(); cpu_we = 0;
        next(); idle(); #2;
        chk("byte_write", cpu_rdata, 32'h0000BEEF);

        // Locked fill of addr 0..7
        for (int i = 0; i < 8; i++) begin
            next(); dma_req = 1; dma_lock = 1; dma_we = 4'hF; dma_addr = 8'(i);
            dma_wdata = 32'hA000_0000 + 32'(i);
            cpu_req = (i != 0); cpu_we = 0; cpu_addr = 8'h03; #2;
            chk("fill_dma_gnt", 32'(dma_gnt), 32'h1);
            if (i > 0) chk("fill_stall", 32'(cpu_stall), 32'h1);
        end
        next(); dma_req = 0; dma_lock = 0; dma_we = 0; #2;
        chk("unlock_cycle_stall", 32'(cpu_stall), 32'h1);
        next(); #2;
        chk("unlock_cpu_gnt", 32'(cpu_gnt), 32'h1);
        next(); idle(); #2;
        chk("fill_readback", cpu_rdata, 32'hA000_0003);

        // Read routing
        next(); dma_req = 1; dma_addr = 8'h05; #2;
        chk("route_dma_gnt", 32'(dma_gnt), 32'h1);
        next(); idle(); cpu_req = 1; cpu_addr = 8'h06; #2;
        chk("route_dma_rvalid", 32'(dma_rvalid), 32'h1);
        chk("route_dma_rdata", dma_rdata, 32'hA000_0005);
        chk("route_cpu_rvalid0", 32'(cpu_rvalid), 32'h0);
        next(); idle(); #2;
        chk("route_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("route_cpu_rdata", cpu_rdata, 32'hA000_0006);
        chk("route_dma_rvalid0", 32'(dma_rvalid), 32'h0);
        next(); #2;
        chk("route_dma_hold", dma_rdata, 32'hA000_0005);

        // Reset with a CPU read outstanding
        next(); cpu_req = 1; cpu_addr = 8'h11;
        next(); rst = 1; idle(); #2;
        chk("rstrd_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rstrd_hold", cpu_rdata, 32'hA000_0006);
        for (int i = 0; i < 5; i++) begin
            next(); rst = 0; cpu_req = 1; dma_req = 1; cpu_addr = 8'h20; dma_addr = 8'h21; #2;
            if (i == 0) begin
                chk("rstrd_cpu_rdata", cpu_rdata, 32'h0);
                chk("rstrd_dma_rdata", dma_rdata, 32'h0);
            end
            chk("rstrd_starve", 32'(cpu_gnt), 32'(i != 4));
        end
        next(); idle();
        next(); next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
